imem_prog_loader: RTL

Writer side of the instruction memory that the pipelined core fetches from. The block accepts a framed byte stream on a valid/ready interface. It assembles little-endian 32-bit instruction words, writes them into IMEM through a single write port, and verifies an XOR checksum. While a load is in progress it holds the core in reset through `core_hold`, and releases the core only after a good frame.

---
 rtl/imem_prog_loader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_prog_loader.sv
// IMEM program loader: framed byte stream -> little-endian 32-bit IMEM writes with XOR check.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module imem_prog_loader #(
   parameter int unsigned ADDR_W        = 5,
   parameter bit          HOLD_ON_RESET = 1'b1
`ifdef LOADER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC   = 1024
`endif
) (
   input  logic              clk,
   input  logic              RN,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_written
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [7:0]  SYNC  = 8'hA5;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_CSUM = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       word_q, word_d;
   logic [7:0]        xor_q, xor_d;
   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  ww_q, ww_d;
   logic [CNT_W-1:0]  ww_inc;
   logic [31:0]       word_next;
   logic              accept;
   logic              timeout_hit;

   assign accept    = in_valid && ready_q;
   assign ww_inc    = ww_q + CNT_W'(1);
   assign word_next = {in_data, word_q[31:8]};

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] tcnt_q;
   logic            in_frame;

   assign in_frame    = (state_q == S_LEN) || (state_q == S_ADDR) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
   assign timeout_hit = in_frame && !accept && (tcnt_q == TO_W'(TIMEOUT_CYC - 1));

   // Idle-cycle counter, cleared by every accepted byte and outside a frame
   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         tcnt_q <= '0;
      end else if (!in_frame || accept) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_q + TO_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      lane_d  = lane_q;
      word_d  = word_q;
      xor_d   = xor_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      err_d   = err_q;
      ww_d    = ww_q;

      case (state_q)
         S_IDLE, S_ERR: begin
            if (accept && (in_data == SYNC)) begin
               state_d = S_LEN;
               hold_d  = 1'b1;
               err_d   = 1'b0;
               ww_d    = '0;
               xor_d   = '0;
            end
         end
         S_LEN: begin
            if (accept) begin
               if ((in_data == 8'd0) || (32'(in_data) > DEPTH)) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  len_d   = CNT_W'(in_data);
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (accept) begin
               ptr_d   = ADDR_W'(in_data);
               lane_d  = 2'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               xor_d  = xor_q ^ in_data;
               word_d = word_next;
               lane_d = lane_q + 2'd1;
               // Last lane completes the word; it is written on the following cycle
               if (lane_q == 2'd3) begin
                  we_d    = 1'b1;
                  wdata_d = word_next;
                  addr_d  = ptr_q;
                  ptr_d   = ptr_q + ADDR_W'(1);
                  ww_d    = ww_inc;
                  if (ww_inc == len_q) begin
                     state_d = S_CSUM;
                  end
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (in_data == xor_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (timeout_hit) begin
         state_d = S_ERR;
         err_d   = 1'b1;
         hold_d  = 1'b1;
      end

      ready_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         ptr_q   <= '0;
         lane_q  <= '0;
         word_q  <= '0;
         xor_q   <= '0;
         ready_q <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= HOLD_ON_RESET;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ww_q    <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         xor_q   <= xor_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ww_q    <= ww_d;
      end
   end

   assign in_ready      = ready_q;
   assign imem_we       = we_q;
   assign imem_addr     = addr_q;
   assign imem_wdata    = wdata_q;
   assign core_hold     = hold_q;
   assign load_done     = done_q;
   assign load_err      = err_q;
   assign words_written = ww_q;

endmodule
